imem_load_arbiter: RTL

Arbiter and load sequencer for the 128 × 16-bit instruction memory. In normal operation it passes the CPU fetch address through to the memory. On a load request it takes the memory away from the CPU, stalls the CPU, and assembles a byte stream from a loader into 16-bit words written from word 0 upward. When the load ends, it pulses a CPU restart and returns the memory to the fetch path.

---
 rtl/imem_load_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/imem_load_arbiter.sv
// ---------------------------------------------------------------------------
// imem_load_arbiter
//
// Arbiter and load sequencer for a 128 x 16-bit instruction memory.
// In IDLE the CPU fetch address passes straight through to the memory.
// A load request takes the memory away from the CPU, stalls the CPU and
// assembles a little-endian byte stream into 16-bit words written from
// word 0 upward. When the stream ends, the CPU gets a one-cycle restart
// pulse and the memory returns to the fetch path.
//
// Ports:
//   CLK          clock, rising edge
//   RESET        asynchronous active-high reset
//   CPU_ADDR     CPU byte fetch address (bit 0 ignored)
//   CPU_STALL    CPU must hold its PC while high
//   CPU_RESTART  one-cycle pulse: CPU resets PC to 0
//   LD_START     load request, honoured in IDLE only
//   LD_VALID     LD_BYTE valid this cycle
//   LD_BYTE      stream byte, low byte of each word first
//   LD_LAST      marks the final byte of the stream
//   LD_READY     byte accepted when LD_VALID && LD_READY
//   LD_DONE      one-cycle completion pulse
//   LD_ERR       sticky overflow flag, cleared by the next load start
//   LD_WORDS     words written by the last/current load (0..DEPTH)
//   MEM_ADDR     memory word address
//   MEM_WE       memory write enable
//   MEM_WDATA    memory write data
// ---------------------------------------------------------------------------
module imem_load_arbiter #(
    parameter int          DEPTH = 128,
    parameter logic [15:0] FILL  = 16'h0000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [7:0]  CPU_ADDR,
    output logic        CPU_STALL,
    output logic        CPU_RESTART,
    input  logic        LD_START,
    input  logic        LD_VALID,
    input  logic [7:0]  LD_BYTE,
    input  logic        LD_LAST,
    output logic        LD_READY,
    output logic        LD_DONE,
    output logic        LD_ERR,
    output logic [7:0]  LD_WORDS,
    output logic [6:0]  MEM_ADDR,
    output logic        MEM_WE,
    output logic [15:0] MEM_WDATA
);

    localparam logic [7:0] WORDS_MAX = 8'(DEPTH);
    localparam logic [6:0] WP_MAX    = 7'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        FINISH = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t      state;
    logic [6:0]  wp;          // next word address to write
    logic [6:0]  waddr_p1;    // address of the write being presented
    logic        phase_hi;    // 1: next accepted byte is the high byte
    logic [7:0]  held_lo;     // low byte waiting for its partner

    logic        accept;
    logic        word_done;
    logic [15:0] word;

    // LD_READY is only ever high in LOAD, so it doubles as the state qualifier.
    assign accept    = LD_READY && LD_VALID;
    // A word completes on a high byte, or early when the stream ends on a low byte.
    assign word_done = accept && (phase_hi || LD_LAST);
    assign word      = phase_hi ? {LD_BYTE, held_lo} : {FILL[15:8], LD_BYTE};

    // Fetch path in IDLE; otherwise the pending write address, or the write
    // pointer when no write is being presented.
    assign MEM_ADDR = (state == IDLE) ? CPU_ADDR[7:1]
                    : (MEM_WE ? waddr_p1 : wp);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= IDLE;
            wp          <= 7'd0;
            waddr_p1    <= 7'd0;
            phase_hi    <= 1'b0;
            held_lo     <= 8'd0;
            LD_WORDS    <= 8'd0;
            LD_ERR      <= 1'b0;
            LD_READY    <= 1'b0;
            LD_DONE     <= 1'b0;
            CPU_STALL   <= 1'b0;
            CPU_RESTART <= 1'b0;
            MEM_WE      <= 1'b0;
            MEM_WDATA   <= 16'd0;
        end else begin
            // Writes last exactly one cycle.
            MEM_WE <= 1'b0;
            case (state)
                IDLE: begin
                    if (LD_START) begin
                        state     <= LOAD;
                        wp        <= 7'd0;
                        LD_WORDS  <= 8'd0;
                        LD_ERR    <= 1'b0;
                        phase_hi  <= 1'b0;
                        CPU_STALL <= 1'b1;
                        LD_READY  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        // Low byte without LAST moves to HIGH; everything else back to LOW.
                        phase_hi <= ~phase_hi & ~LD_LAST;
                        if (!phase_hi) begin
                            held_lo <= LD_BYTE;
                        end
                        // Write stage boundary: completed word registered for next cycle.
                        if (word_done) begin
                            if (LD_WORDS < WORDS_MAX) begin
                                MEM_WE    <= 1'b1;
                                MEM_WDATA <= word;
                                waddr_p1  <= wp;
                                LD_WORDS  <= LD_WORDS + 8'd1;
                                // Pointer parks on the top word instead of wrapping.
                                if (wp != WP_MAX) begin
                                    wp <= wp + 7'd1;
                                end
                            end else begin
                                LD_ERR <= 1'b1;
                            end
                        end
                        if (LD_LAST) begin
                            state    <= FINISH;
                            LD_READY <= 1'b0;
                        end
                    end
                end
                FINISH: begin
                    state       <= DONE;
                    LD_DONE     <= 1'b1;
                    CPU_RESTART <= 1'b1;
                end
                DONE: begin
                    state       <= IDLE;
                    LD_DONE     <= 1'b0;
                    CPU_RESTART <= 1'b0;
                    CPU_STALL   <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
